uart_frame_buffer: RTL and testbench

UART_FRAME_BUFFER -- requirements
Module: uart_frame_buffer

---
 rtl/uart_frame_buffer.sv | 105 ++++++++++
 tb/tb_uart_frame_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_buffer.sv
// rtl/uart_frame_buffer.sv - checks captured UART frames and buffers the good data bytes in a FIFO
module uart_frame_buffer #(
  parameter int FRAME_W = 12,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_valid,
  input  logic [FRAME_W-1:0] frame,
  input  logic               pop,
  input  logic               clear_err,
  output logic [7:0]         rd_data,
  output logic               rd_valid,
  output logic               full,
  output logic [CNT_W-1:0]   count,
  output logic               frame_err,
  output logic               overflow,
  output logic [7:0]         err_count,
  output logic [7:0]         drop_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic good;
  logic space;
  logic do_push;
  logic do_pop;
  logic drop_ev;
  logic err_ev;
  logic unused_hi;

  assign unused_hi = ^frame[FRAME_W-1:10];

  assign rd_valid = (count != '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign rd_data  = mem[rd_ptr];

  // A full FIFO still has room when the head leaves on the same edge.
  assign good    = (frame[0] == 1'b0) && (frame[9] == 1'b1);
  assign space   = !full || pop;
  assign do_pop  = pop && rd_valid;
  assign do_push = frame_valid && good && space;
  assign drop_ev = frame_valid && good && !space;
  assign err_ev  = frame_valid && !good;

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem[wr_ptr] <= frame[8:1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Clearing wins over the old value but not over an event in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      err_count  <= 8'd0;
      drop_count <= 8'd0;
    end else if (clear_err) begin
      frame_err  <= err_ev;
      overflow   <= drop_ev;
      err_count  <= {7'd0, err_ev};
      drop_count <= {7'd0, drop_ev};
    end else begin
      if (err_ev) begin
        frame_err <= 1'b1;
        if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end
      if (drop_ev) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_buffer.sv
// tb/tb_uart_frame_buffer.sv - randomized and directed checks of uart_frame_buffer against a queue model
module tb_uart_frame_buffer;

  localparam int FRAME_W = 12;
  localparam int DEPTH   = 16;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               frame_valid = 1'b0;
  logic [FRAME_W-1:0] frame = '0;
  logic               pop = 1'b0;
  logic               clear_err = 1'b0;
  logic [7:0]         rd_data;
  logic               rd_valid;
  logic               full;
  logic [CNT_W-1:0]   count;
  logic               frame_err;
  logic               overflow;
  logic [7:0]         err_count;
  logic [7:0]         drop_count;

  uart_frame_buffer #(.FRAME_W(FRAME_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame(frame), .pop(pop),
    .clear_err(clear_err), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
    .count(count), .frame_err(frame_err), .overflow(overflow),
    .err_count(err_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  byte unsigned m_q[$];
  bit           m_ferr = 1'b0;
  bit           m_ovf = 1'b0;
  int           m_ecnt = 0;
  int           m_dcnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Model: the FIFO is a queue of bytes, flags and counters are plain integers.
  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_ferr = 0; m_ovf = 0; m_ecnt = 0; m_dcnt = 0;
    end else begin
      bit good, accept, drop_e, err_e, pop_e;
      good   = frame_valid && frame[0] == 1'b0 && frame[9] == 1'b1;
      err_e  = frame_valid && !(frame[0] == 1'b0 && frame[9] == 1'b1);
      pop_e  = pop && m_q.size() > 0;
      accept = good && (m_q.size() < DEPTH || pop);
      drop_e = good && !accept;
      if (pop_e) void'(m_q.pop_front());
      if (accept) m_q.push_back(frame[8:1]);
      if (clear_err) begin
        m_ferr = err_e; m_ecnt = err_e ? 1 : 0;
        m_ovf = drop_e; m_dcnt = drop_e ? 1 : 0;
      end else begin
        if (err_e) begin m_ferr = 1; if (m_ecnt < 255) m_ecnt++; end
        if (drop_e) begin m_ovf = 1; if (m_dcnt < 255) m_dcnt++; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", int'(count), m_q.size());
      chk("rd_valid", int'(rd_valid), (m_q.size() > 0) ? 1 : 0);
      chk("full", int'(full), (m_q.size() == DEPTH) ? 1 : 0);
      if (m_q.size() > 0) chk("rd_data", int'(rd_data), int'(m_q[0]));
      chk("frame_err", int'(frame_err), int'(m_ferr));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("err_count", int'(err_count), m_ecnt);
      chk("drop_count", int'(drop_count), m_dcnt);
    end
  end

  function automatic logic [FRAME_W-1:0] mk(input logic [7:0] d, input bit ok);
    logic [1:0] hi;
    logic       bad_sel;
    hi = 2'($urandom);
    bad_sel = 1'($urandom);
    if (ok) return {hi, 1'b1, d, 1'b0};
    if (bad_sel) return {hi, 1'b0, d, 1'($urandom)};
    return {hi, 1'b1, d, 1'b1};
  endfunction

  task automatic cyc(input bit fv, input logic [FRAME_W-1:0] fr, input bit p, input bit c, input bit r);
    frame_valid = fv; frame = fr; pop = p; clear_err = c; rst = r;
    @(posedge clk);
    @(negedge clk);
    frame_valid = 1'b0; pop = 1'b0; clear_err = 1'b0; rst = 1'b0;
  endtask

  logic [7:0] exp_bytes [DEPTH];
  logic [7:0] newb;

  initial begin
    @(negedge clk);
    cyc(0, '0, 0, 0, 1);
    cyc(1, mk(8'h11, 1), 1, 1, 1);
    chk_en = 1'b1;
    chk("rst_count", int'(count), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_full", int'(full), 0);

    cyc(1, 12'h2A4, 0, 0, 0);
    chk("dir_rd_valid", int'(rd_valid), 1);
    chk("dir_rd_data", int'(rd_data), 8'h52);
    chk("dir_count", int'(count), 1);
    chk("dir_no_err", int'(frame_err), 0);

    cyc(1, 12'h0A5, 0, 0, 0);
    chk("bad_count", int'(count), 1);
    chk("bad_ferr", int'(frame_err), 1);
    chk("bad_ecnt", int'(err_count), 1);
    cyc(0, '0, 0, 1, 0);
    chk("clr_ferr", int'(frame_err), 0);
    chk("clr_ecnt", int'(err_count), 0);
    chk("clr_keeps_fifo", int'(count), 1);

    cyc(0, '0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) begin
      exp_bytes[i] = 8'($urandom);
      cyc(1, mk(exp_bytes[i], 1), 0, 0, 0);
    end
    cyc(1, mk(8'hEE, 1), 0, 0, 0);
    chk("ovf_full", int'(full), 1);
    chk("ovf_count", int'(count), 16);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_dcnt", int'(drop_count), 1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", int'(rd_data), int'(exp_bytes[i]));
      cyc(0, '0, 1, 0, 0);
    end
    chk("drain_empty", int'(rd_valid), 0);

    for (int i = 0; i < DEPTH; i++) cyc(1, mk(8'($urandom), 1), 0, 0, 0);
    cyc(0, '0, 0, 1, 0);
    newb = 8'hC3;
    cyc(1, mk(newb, 1), 1, 0, 0);
    chk("fullpp_count", int'(count), 16);
    chk("fullpp_ovf", int'(overflow), 0);
    for (int i = 0; i < DEPTH - 1; i++) cyc(0, '0, 1, 0, 0);
    chk("fullpp_last", int'(rd_data), int'(newb));
    cyc(0, '0, 1, 0, 0);

    cyc(0, '0, 1, 0, 0);
    chk("underflow_count", int'(count), 0);
    cyc(1, mk(8'h5A, 1), 1, 0, 0);
    chk("empty_pp_count", int'(count), 1);
    chk("empty_pp_data", int'(rd_data), 8'h5A);
    cyc(0, '0, 1, 0, 0);

    for (int i = 0; i < 20; i++) begin
      cyc(1, mk(8'(i * 7 + 3), 1), 0, 0, 0);
      chk("wrap_data", int'(rd_data), (i * 7 + 3) & 255);
      cyc(0, '0, 1, 0, 0);
    end
    for (int i = 0; i < 5; i++) cyc(1, mk(8'($urandom), 1), 0, 0, 0);
    cyc(1, mk(8'h77, 1), 0, 0, 1);
    chk("midrst_count", int'(count), 0);
    chk("midrst_valid", int'(rd_valid), 0);

    for (int i = 0; i < 300; i++) cyc(1, mk(8'($urandom), 0), 0, 0, 0);
    chk("sat_ecnt", int'(err_count), 255);

    for (int i = 0; i < 3000; i++) begin
      bit fv, ok, p, c, r;
      fv = ($urandom_range(0, 99) < 60);
      ok = ($urandom_range(0, 99) < 85);
      p  = ($urandom_range(0, 99) < 40);
      c  = ($urandom_range(0, 99) < 3);
      r  = ($urandom_range(0, 999) < 4);
      cyc(fv, fv ? mk(8'($urandom), ok) : FRAME_W'($urandom), p, c, r);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
